// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store alignment unit: access-size
// encodings, FSM state type, datapath widths and small decode helpers.
package lsu_pkg;

  localparam int DATA_W = 64;
  localparam int OFF_W  = 3;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD    = 2'd1,
    ST_MERGE = 2'd2,
    ST_WR    = 2'd3
  } lsu_state_e;

  // Right-aligned mask covering the bytes of one access of the given size.
  function automatic logic [DATA_W-1:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_B:  return 64'h0000_0000_0000_00FF;
      SIZE_H:  return 64'h0000_0000_0000_FFFF;
      SIZE_W:  return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // An access is misaligned when its byte offset is not a multiple of its size.
  function automatic logic misaligned(input logic [1:0] size, input logic [OFF_W-1:0] off);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return off[0];
      SIZE_W:  return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane steering: extracts and extends load data from a
// memory doubleword, and inserts store data into an old doubleword.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [OFF_W-1:0]  off_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] ld_data_o,
  output logic [DATA_W-1:0] st_word_o
);

  logic [5:0]        shamt;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;

  assign shamt   = {off_i, 3'b000};
  assign shifted = rdata_i >> shamt;
  assign mask    = size_mask(size_i);

  // Load path: shift the addressed bytes down, then sign- or zero-extend.
  always_comb begin
    ld_data_o = shifted;
    case (size_i)
      SIZE_B:  ld_data_o = {{56{~unsigned_i & shifted[7]}},  shifted[7:0]};
      SIZE_H:  ld_data_o = {{48{~unsigned_i & shifted[15]}}, shifted[15:0]};
      SIZE_W:  ld_data_o = {{32{~unsigned_i & shifted[31]}}, shifted[31:0]};
      default: ld_data_o = shifted;
    endcase
  end

  // Store path: clear the target bytes of the old word and OR in the new data.
  assign st_word_o = (rdata_i & ~(mask << shamt)) | ((wdata_i & mask) << shamt);

endmodule

// File: rtl/lsu_align_unit.sv
// Load/store unit between execute and a 64-bit doubleword-indexed memory.
// Handles B/H/W/D accesses, load extension and read-modify-write stores.
// Build option LSU_RMW_EN: when defined, B/H/W stores run read-modify-write;
// when undefined they are rejected as errors at accept.
module lsu_align_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [63:0]       req_addr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  output logic              resp_err_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic [63:0]       mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_we_o,
  output logic              mem_re_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  lsu_state_e        state_q, state_d;
  logic [63:0]       addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

  logic              range_err;
  logic              size_err;
  logic              req_err;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] st_word;

  assign range_err = req_addr_i[63:3] >= 61'(DEPTH);
`ifdef LSU_RMW_EN
  assign size_err  = 1'b0;
`else
  assign size_err  = req_we_i && (req_size_i != SIZE_D);
`endif
  assign req_err   = misaligned(req_size_i, req_addr_i[2:0]) || range_err || size_err;

  lsu_byte_lane u_lane (
    .off_i      (addr_q[2:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .rdata_i    (mem_rdata_i),
    .wdata_i    (wdata_q),
    .ld_data_o  (ld_data),
    .st_word_o  (st_word)
  );

  // Next-state, request capture and response generation.
  always_comb begin
    // NOTE: every signal gets its default first so no path leaves one unassigned (no latches).
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          we_d    = req_we_i;
          wdata_d = req_wdata_i;
          if (req_err) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (req_we_i && (req_size_i == SIZE_D)) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD:    state_d = ST_MERGE;
      ST_MERGE: begin
        if (we_q) begin
          wdata_d = st_word;
          state_d = ST_WR;
        end else begin
          resp_valid_d = 1'b1;
          resp_rdata_d = ld_data;
          state_d      = ST_IDLE;
        end
      end
      ST_WR: begin
        resp_valid_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, request and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      size_q       <= SIZE_B;
      uns_q        <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Memory strobes come from state alone, so reset drops mem_we_o at once.
  assign mem_re_o     = (state_q == ST_RD);
  assign mem_we_o     = (state_q == ST_WR);
  assign mem_addr_o   = {3'b000, addr_q[63:3]};
  assign mem_wdata_o  = wdata_q;
  assign req_ready_o  = (state_q == ST_IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;

endmodule

// File: tb/tb_lsu_align_unit.sv
// Self-checking bench for lsu_align_unit with a byte-level reference model
// and a registered-read memory. Expectations follow LSU_RMW_EN.
module tb_lsu_align_unit;

  localparam int DEPTH = 1024;
`ifdef LSU_RMW_EN
  localparam bit RMW_EN = 1'b1;
`else
  localparam bit RMW_EN = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
    logic [3:0]  lat;
    logic [1:0]  n_re;
    logic [1:0]  n_we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        both;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [63:0] req_addr = '0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_err;
  logic [63:0] resp_rdata;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [63:0] mem_rdata;

  logic [63:0] dmem    [DEPTH];
  logic [63:0] ref_mem [DEPTH];
  logic        mem_init_done = 1'b0;
  int          we_edges = 0;
  int          tests_run = 0;
  int          failures = 0;

  lsu_align_unit #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_addr_i     (req_addr),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_wdata_i    (req_wdata),
    .resp_valid_o   (resp_valid),
    .resp_err_o     (resp_err),
    .resp_rdata_o   (resp_rdata),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_we_o       (mem_we),
    .mem_re_o       (mem_re),
    .mem_rdata_i    (mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: loaded from the reference image, then registered read/write.
  initial begin
    mem_rdata = '0;
    wait (mem_init_done);
    for (int i = 0; i < DEPTH; i++) dmem[i] = ref_mem[i];
    forever begin
      @(posedge clk);
      if (mem_we && mem_addr < 64'(DEPTH)) dmem[mem_addr[9:0]] <= mem_wdata;
      if (mem_re) mem_rdata <= (mem_addr < 64'(DEPTH)) ? dmem[mem_addr[9:0]] : 64'hDEAD_BEEF_DEAD_BEEF;
    end
  end

  always @(posedge clk) if (mem_we) we_edges <= we_edges + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: what a request must produce, working byte by byte.
  function automatic obs_t model(input logic we, input logic [63:0] addr, input logic [1:0] size,
                                 input logic uns, input logic [63:0] wd);
    obs_t        e;
    int          nb;
    int          off;
    logic [63:0] idx;
    logic [63:0] v;
    e   = '0;
    nb  = 1 << size;
    off = int'(addr[2:0]);
    idx = addr >> 3;
    if ((addr % 64'(nb)) != 0 || idx >= 64'(DEPTH) || (we && nb < 8 && !RMW_EN)) begin
      e.err = 1'b1;
      e.lat = 4'd1;
      return e;
    end
    e.addr = idx;
    if (!we) begin
      v = '0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[idx[9:0]][8*(off+i) +: 8];
      if (!uns && nb < 8 && v[8*nb-1])
        for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
      e.rdata = v;
      e.lat   = 4'd3;
      e.n_re  = 2'd1;
    end else begin
      for (int i = 0; i < nb; i++) ref_mem[idx[9:0]][8*(off+i) +: 8] = wd[8*i +: 8];
      e.lat   = (nb == 8) ? 4'd2 : 4'd4;
      e.n_re  = (nb == 8) ? 2'd0 : 2'd1;
      e.n_we  = 2'd1;
      e.wdata = ref_mem[idx[9:0]];
    end
    return e;
  endfunction

  task automatic show(input string name, input obs_t o, input obs_t e);
    $display("FAIL %s: got rdata=%h err=%0b lat=%0d re=%0d we=%0d addr=%0h wdata=%h both=%0b | want rdata=%h err=%0b lat=%0d re=%0d we=%0d addr=%0h wdata=%h both=%0b",
             name, o.rdata, o.err, o.lat, o.n_re, o.n_we, o.addr, o.wdata, o.both,
             e.rdata, e.err, e.lat, e.n_re, e.n_we, e.addr, e.wdata, e.both);
  endtask

  // Watch memory strobes and wait, bounded, for the response pulse.
  task automatic collect(output obs_t o);
    o = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_re) o.n_re = o.n_re + 2'd1;
      if (mem_we) begin
        o.n_we  = o.n_we + 2'd1;
        o.wdata = mem_wdata;
      end
      if (mem_re || mem_we) o.addr = mem_addr;
      if (mem_re && mem_we) o.both = 1'b1;
      if (resp_valid) begin
        o.lat   = 4'(c);
        o.rdata = resp_rdata;
        o.err   = resp_err;
        break;
      end
    end
  endtask

  task automatic drive(input logic we, input logic [63:0] addr, input logic [1:0] size,
                       input logic uns, input logic [63:0] wd, output obs_t o);
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wd;
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_we       = 1'($urandom);
    req_addr     = {$urandom, $urandom};
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_wdata    = {$urandom, $urandom};
    collect(o);
  endtask

  task automatic test_reset();
    logic [63:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      v = {$urandom, $urandom};
      ref_mem[i] = v;
    end
    ref_mem[0] = 64'h8877_6655_4433_2211;
    ref_mem[2] = 64'h0;
    mem_init_done = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({resp_valid, resp_err, resp_rdata, mem_we, mem_re, mem_addr, mem_wdata, req_ready} !==
        {1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1}) begin
      failures++;
      $display("FAIL reset_values: got vld=%0b err=%0b rdata=%h we=%0b re=%0b addr=%h wdata=%h rdy=%0b, want all zero with rdy=1",
               resp_valid, resp_err, resp_rdata, mem_we, mem_re, mem_addr, mem_wdata, req_ready);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({resp_valid, mem_we, mem_re, req_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL idle_after_reset: got vld=%0b we=%0b re=%0b rdy=%0b, want 0 0 0 1",
               resp_valid, mem_we, mem_re, req_ready);
    end
  endtask

  task automatic test_loads();
    logic [63:0] la [4] = '{64'h7, 64'h7, 64'h2, 64'h4};
    logic [1:0]  ls [4] = '{2'b00, 2'b00, 2'b01, 2'b10};
    logic        lu [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [63:0] lx [4] = '{64'hFFFF_FFFF_FFFF_FF88, 64'h88, 64'h4433, 64'h8877_6655};
    obs_t o, e;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, la[i], ls[i], lu[i], 64'h0, o);
      e = '0;
      e.rdata = lx[i];
      e.lat   = 4'd3;
      e.n_re  = 2'd1;
      tests_run++;
      if (o !== e) begin
        failures++;
        show($sformatf("load_%0d", i), o, e);
      end
    end
    @(negedge clk);
    tests_run++;
    if (resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL resp_pulse_width: got resp_valid=%0b one cycle later, want 0", resp_valid);
    end
  endtask

  task automatic test_store_rmw();
    obs_t        o, e;
    logic [63:0] want_word;
    want_word = RMW_EN ? 64'h0000_0000_BEEF_0000 : 64'h0;
    drive(1'b1, 64'h12, 2'b01, 1'b0, 64'hBEEF, o);
    e = '0;
    if (RMW_EN) begin
      e.lat = 4'd4; e.n_re = 2'd1; e.n_we = 2'd1; e.addr = 64'd2; e.wdata = want_word;
    end else begin
      e.err = 1'b1; e.lat = 4'd1;
    end
    void'(model(1'b1, 64'h12, 2'b01, 1'b0, 64'hBEEF));
    tests_run++;
    if (o !== e) begin failures++; show("store_sh_beef", o, e); end
    tests_run++;
    if (dmem[2] !== want_word) begin
      failures++;
      $display("FAIL store_sh_mem: got word2=%h want %h", dmem[2], want_word);
    end
    drive(1'b0, 64'h10, 2'b11, 1'b0, 64'h0, o);
    e = '0; e.rdata = want_word; e.lat = 4'd3; e.n_re = 2'd1; e.addr = 64'd2;
    tests_run++;
    if (o !== e) begin failures++; show("load_after_sh", o, e); end
    drive(1'b1, 64'h1D, 2'b00, 1'b0, 64'h1234_5678_9ABC_DEA5, o);
    e = model(1'b1, 64'h1D, 2'b00, 1'b0, 64'h1234_5678_9ABC_DEA5);
    tests_run++;
    if (o !== e) begin failures++; show("store_sb_off5", o, e); end
    drive(1'b1, 64'h24, 2'b10, 1'b0, 64'hFFFF_FFFF_CAFE_F00D, o);
    e = model(1'b1, 64'h24, 2'b10, 1'b0, 64'hFFFF_FFFF_CAFE_F00D);
    tests_run++;
    if (o !== e) begin failures++; show("store_sw_off4", o, e); end
    tests_run++;
    if (dmem[3] !== ref_mem[3] || dmem[4] !== ref_mem[4]) begin
      failures++;
      $display("FAIL store_sb_sw_mem: got w3=%h w4=%h want w3=%h w4=%h", dmem[3], dmem[4], ref_mem[3], ref_mem[4]);
    end
  endtask

  task automatic test_errors();
    logic [63:0] ea [5] = '{64'h6, 64'h2000, 64'h1, 64'h1FF8, 64'h1FF8};
    logic [1:0]  es [5] = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b11};
    logic        ew [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    obs_t        o, e;
    logic [63:0] wd;
    for (int i = 0; i < 5; i++) begin
      wd = {$urandom, $urandom};
      drive(ew[i], ea[i], es[i], 1'b0, wd, o);
      e = model(ew[i], ea[i], es[i], 1'b0, wd);
      tests_run++;
      if (o !== e) begin failures++; show($sformatf("error_case_%0d", i), o, e); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t        o, e;
    logic [63:0] v;
    int          lat;
    v = {$urandom, $urandom};
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h0; req_size = 2'b11;
    req_unsigned = 1'b0; req_wdata = v;
    @(posedge clk);
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (resp_valid) begin lat = c; break; end
    end
    void'(model(1'b1, 64'h0, 2'b11, 1'b0, v));
    tests_run++;
    if (lat != 2 || req_ready !== 1'b1 || resp_err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_store: got lat=%0d ready=%0b err=%0b, want lat=2 ready=1 err=0", lat, req_ready, resp_err);
    end
    req_we = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    collect(o);
    e = model(1'b0, 64'h0, 2'b11, 1'b0, 64'h0);
    tests_run++;
    if (o !== e) begin failures++; show("b2b_load", o, e); end
  endtask

  task automatic test_reset_mid_op();
    int          we_before;
    int          stray;
    logic [63:0] old0;
    old0 = ref_mem[0];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h3; req_size = 2'b00;
    req_unsigned = 1'b0; req_wdata = 64'h5A;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    we_before = we_edges;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({resp_valid, resp_err, resp_rdata, mem_we, mem_re, mem_addr, mem_wdata, req_ready} !==
        {1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1}) begin
      failures++;
      $display("FAIL midop_reset_values: got vld=%0b err=%0b rdata=%h we=%0b re=%0b addr=%h wdata=%h rdy=%0b, want all zero with rdy=1",
               resp_valid, resp_err, resp_rdata, mem_we, mem_re, mem_addr, mem_wdata, req_ready);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid || mem_we || mem_re) stray++;
    end
    tests_run++;
    if (stray != 0 || we_edges != we_before || dmem[0] !== old0) begin
      failures++;
      $display("FAIL midop_no_effect: got stray=%0d we_edges=%0d->%0d word0=%h, want 0 unchanged word0=%h",
               stray, we_before, we_edges, dmem[0], old0);
    end
  endtask

  task automatic test_random();
    obs_t        o, e;
    logic        we, uns;
    logic [1:0]  size;
    logic [63:0] addr, wd, idx;
    int          nb, off;
    for (int n = 0; n < 60; n++) begin
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      nb   = 1 << size;
      wd   = {$urandom, $urandom};
      idx  = ($urandom_range(0, 11) == 0) ? 64'(DEPTH + $urandom_range(0, 50)) : 64'($urandom_range(0, DEPTH - 1));
      off  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : ($urandom_range(0, 7) / nb) * nb;
      addr = (idx << 3) | 64'(off);
      if ($urandom_range(0, 19) == 0) addr[63] = 1'b1;
      drive(we, addr, size, uns, wd, o);
      e = model(we, addr, size, uns, wd);
      tests_run++;
      if (o !== e) begin failures++; show($sformatf("random_%0d", n), o, e); end
      if (we && !e.err) begin
        tests_run++;
        if (dmem[idx[9:0]] !== ref_mem[idx[9:0]]) begin
          failures++;
          $display("FAIL random_mem_%0d: got word=%h want %h", n, dmem[idx[9:0]], ref_mem[idx[9:0]]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_store_rmw();
    test_errors();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
